csr_unit: RTL and testbench

CSR_UNIT -- requirements
Module: csr_unit

---
 rtl/csr_pkg.sv | 36 +++
 rtl/csr_counter.sv | 25 ++
 rtl/csr_unit.sv | 168 ++++++++++++++++
 tb/tb_csr_unit.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// Shared CSR definitions: access ops, CSR addresses, status/enable bit positions
// and interrupt cause codes.
package csr_pkg;

  typedef enum logic [1:0] {
    OP_NONE  = 2'b00,
    OP_WRITE = 2'b01,
    OP_SET   = 2'b10,
    OP_CLEAR = 2'b11
  } csr_op_e;

  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MIE      = 12'h304;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MIP      = 12'h344;
  localparam logic [11:0] ADDR_CYCLE    = 12'hC00;
  localparam logic [11:0] ADDR_INSTRET  = 12'hC02;
  localparam logic [11:0] ADDR_CYCLEH   = 12'hC80;
  localparam logic [11:0] ADDR_INSTRETH = 12'hC82;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;

  // mie and mip share bit positions
  localparam int IRQ_SW  = 3;
  localparam int IRQ_TMR = 7;
  localparam int IRQ_EXT = 11;

  localparam int CAUSE_SW  = 3;
  localparam int CAUSE_TMR = 7;
  localparam int CAUSE_EXT = 11;

endpackage

// File: rtl/csr_counter.sv
// Free-running CNT_W-bit counter exposed as two XLEN-wide read halves.
module csr_counter #(
  parameter int XLEN  = 16,
  parameter int CNT_W = 2 * XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            inc,
  input  logic            clear,
  output logic [XLEN-1:0] lo,
  output logic [XLEN-1:0] hi
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     cnt_q <= '0;
    else if (clear) cnt_q <= '0;
    else if (inc)   cnt_q <= cnt_q + CNT_W'(1);
  end

  assign lo = cnt_q[XLEN-1:0];
  assign hi = XLEN'(cnt_q[CNT_W-1:XLEN]);

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR file: CSR access port, trap/mret sequencing, interrupt
// arbitration and cycle/instret counters.
module csr_unit
  import csr_pkg::*;
#(
  parameter int XLEN  = 16,
  parameter int CNT_W = 2 * XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      ex_op,
  input  logic [11:0]     ex_addr,
  input  logic [XLEN-1:0] ex_wdata,
  output logic [XLEN-1:0] ex_rdata,
  output logic            ex_illegal,
  input  logic            retire,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_cause,
  input  logic [XLEN-1:0] trap_pc,
  input  logic            mret,
  input  logic            ext_irq,
  input  logic            tmr_irq,
  input  logic            sw_irq,
  output logic            int_req,
  output logic [XLEN-1:0] int_cause,
  output logic [XLEN-1:0] trap_vector,
  output logic [XLEN-1:0] mepc_o
);

  localparam logic [XLEN-1:0] MIE_MASK =
    (XLEN'(1) << IRQ_EXT) | (XLEN'(1) << IRQ_TMR) | (XLEN'(1) << IRQ_SW);

  logic            mst_mie_q, mst_mpie_q;
  logic            ext_q, tmr_q, sw_q;
  logic [XLEN-1:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q;
  logic [XLEN-1:0] mip_vec, pend, base;
  logic [XLEN-1:0] cyc_lo, cyc_hi, ret_lo, ret_hi;
  logic [XLEN-1:0] wval;
  logic            known, read_only, wr_en;
  csr_op_e         op;

  function automatic logic [XLEN-1:0] csr_apply(input csr_op_e o,
                                                input logic [XLEN-1:0] old,
                                                input logic [XLEN-1:0] wd);
    case (o)
      OP_WRITE: csr_apply = wd;
      OP_SET:   csr_apply = old | wd;
      OP_CLEAR: csr_apply = old & ~wd;
      default:  csr_apply = old;
    endcase
  endfunction

  assign op = csr_op_e'(ex_op);

  always_comb begin
    mip_vec          = '0;
    mip_vec[IRQ_EXT] = ext_q;
    mip_vec[IRQ_TMR] = tmr_q;
    mip_vec[IRQ_SW]  = sw_q;
  end

  always_comb begin
    ex_rdata  = '0;
    known     = 1'b1;
    read_only = 1'b0;
    case (ex_addr)
      ADDR_MSTATUS: begin
        ex_rdata[MSTATUS_MIE]  = mst_mie_q;
        ex_rdata[MSTATUS_MPIE] = mst_mpie_q;
      end
      ADDR_MIE:      ex_rdata = mie_q;
      ADDR_MTVEC:    ex_rdata = mtvec_q;
      ADDR_MSCRATCH: ex_rdata = mscratch_q;
      ADDR_MEPC:     ex_rdata = mepc_q;
      ADDR_MCAUSE:   ex_rdata = mcause_q;
      ADDR_MIP:      begin ex_rdata = mip_vec; read_only = 1'b1; end
      ADDR_CYCLE:    begin ex_rdata = cyc_lo;  read_only = 1'b1; end
      ADDR_INSTRET:  begin ex_rdata = ret_lo;  read_only = 1'b1; end
      ADDR_CYCLEH:   begin ex_rdata = cyc_hi;  read_only = 1'b1; end
      ADDR_INSTRETH: begin ex_rdata = ret_hi;  read_only = 1'b1; end
      default:       known = 1'b0;
    endcase
  end

  assign ex_illegal = !known || (read_only && (op != OP_NONE));
  // trap beats mret beats CSR access; losers have no effect
  assign wr_en      = (op != OP_NONE) && !ex_illegal && !trap_valid && !mret;
  assign wval       = csr_apply(op, ex_rdata, ex_wdata);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mst_mie_q  <= 1'b0;
      mst_mpie_q <= 1'b0;
      ext_q      <= 1'b0;
      tmr_q      <= 1'b0;
      sw_q       <= 1'b0;
      mie_q      <= '0;
      mtvec_q    <= '0;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
    end else begin
      ext_q <= ext_irq;
      tmr_q <= tmr_irq;
      sw_q  <= sw_irq;
      if (trap_valid) begin
        mepc_q     <= trap_pc & ~XLEN'(1);
        mcause_q   <= trap_cause;
        mst_mpie_q <= mst_mie_q;
        mst_mie_q  <= 1'b0;
      end else if (mret) begin
        mst_mie_q  <= mst_mpie_q;
        mst_mpie_q <= 1'b1;
      end else if (wr_en) begin
        case (ex_addr)
          ADDR_MSTATUS: begin
            mst_mie_q  <= wval[MSTATUS_MIE];
            mst_mpie_q <= wval[MSTATUS_MPIE];
          end
          ADDR_MIE:      mie_q      <= wval & MIE_MASK;
          ADDR_MTVEC:    mtvec_q    <= wval;
          ADDR_MSCRATCH: mscratch_q <= wval;
          ADDR_MEPC:     mepc_q     <= wval & ~XLEN'(1);
          ADDR_MCAUSE:   mcause_q   <= wval;
          default: ;
        endcase
      end
    end
  end

  assign pend    = mie_q & mip_vec;
  assign int_req = mst_mie_q & (|pend);

  always_comb begin
    int_cause = '0;
    if (int_req) begin
      if (pend[IRQ_EXT])     int_cause = {1'b1, (XLEN-1)'(CAUSE_EXT)};
      else if (pend[IRQ_SW]) int_cause = {1'b1, (XLEN-1)'(CAUSE_SW)};
      else                   int_cause = {1'b1, (XLEN-1)'(CAUSE_TMR)};
    end
  end

  // vectored mode only redirects interrupts; exceptions always go to BASE
  assign base        = mtvec_q & ~XLEN'(3);
  assign trap_vector = ((mtvec_q[1:0] == 2'b01) && trap_cause[XLEN-1])
                     ? base + XLEN'({trap_cause[XLEN-2:0], 2'b00})
                     : base;
  assign mepc_o      = mepc_q;

  csr_counter #(.XLEN(XLEN), .CNT_W(CNT_W)) u_cycle (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (1'b1),
    .clear (1'b0),
    .lo    (cyc_lo),
    .hi    (cyc_hi)
  );

  csr_counter #(.XLEN(XLEN), .CNT_W(CNT_W)) u_instret (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (retire & ~trap_valid),
    .clear (1'b0),
    .lo    (ret_lo),
    .hi    (ret_hi)
  );

endmodule

// File: tb/tb_csr_unit.sv
// Directed bench for csr_unit: main instance XLEN=16, plus a narrow
// XLEN=12/CNT_W=13 instance so the full counter wrap is reachable.
module tb_csr_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  ex_op = 2'b00;
  logic [11:0] ex_addr = 12'h300;
  logic [15:0] ex_wdata = '0;
  logic [15:0] ex_rdata;
  logic        ex_illegal;
  logic        retire = 1'b0, trap_valid = 1'b0, mret = 1'b0;
  logic [15:0] trap_cause = '0, trap_pc = '0;
  logic        ext_irq = 1'b0, tmr_irq = 1'b0, sw_irq = 1'b0;
  logic        int_req;
  logic [15:0] int_cause, trap_vector, mepc_o;

  logic        s_rst_n = 1'b0;
  logic [11:0] s_addr = 12'hC00;
  logic [11:0] s_rdata, s_int_cause, s_trap_vector, s_mepc;
  logic        s_illegal, s_int_req;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  csr_unit #(.XLEN(16)) dut (
    .clk(clk), .rst_n(rst_n), .ex_op(ex_op), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
    .ex_rdata(ex_rdata), .ex_illegal(ex_illegal), .retire(retire),
    .trap_valid(trap_valid), .trap_cause(trap_cause), .trap_pc(trap_pc), .mret(mret),
    .ext_irq(ext_irq), .tmr_irq(tmr_irq), .sw_irq(sw_irq), .int_req(int_req),
    .int_cause(int_cause), .trap_vector(trap_vector), .mepc_o(mepc_o)
  );

  csr_unit #(.XLEN(12), .CNT_W(13)) dut_s (
    .clk(clk), .rst_n(s_rst_n), .ex_op(2'b00), .ex_addr(s_addr), .ex_wdata(12'h000),
    .ex_rdata(s_rdata), .ex_illegal(s_illegal), .retire(1'b0),
    .trap_valid(1'b0), .trap_cause(12'h000), .trap_pc(12'h000), .mret(1'b0),
    .ext_irq(1'b0), .tmr_irq(1'b0), .sw_irq(1'b0), .int_req(s_int_req),
    .int_cause(s_int_cause), .trap_vector(s_trap_vector), .mepc_o(s_mepc)
  );

  task automatic read_csr(input logic [11:0] a, output logic [15:0] d);
    ex_op = 2'b00; ex_addr = a; #1; d = ex_rdata;
  endtask

  task automatic csr_op(input logic [1:0] op, input logic [11:0] a, input logic [15:0] wd,
                        output logic [15:0] old, output logic ill);
    @(negedge clk);
    ex_op = op; ex_addr = a; ex_wdata = wd; #1;
    old = ex_rdata; ill = ex_illegal;
    @(posedge clk); #1;
    ex_op = 2'b00;
  endtask

  task automatic s_read(input logic [11:0] a, output logic [11:0] d);
    s_addr = a; #1; d = s_rdata;
  endtask

  task automatic test_reset;
    logic [15:0] d, old;
    logic ill;
    ext_irq = 1'b1; trap_cause = 16'h800B;
    repeat (2) @(posedge clk); #1;
    checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL rst_int_req: got %b want 0", int_req); end
    checks++; if (int_cause !== 16'h0000) begin errors++; $display("FAIL rst_int_cause: got %h want 0000", int_cause); end
    checks++; if (trap_vector !== 16'h0000) begin errors++; $display("FAIL rst_trap_vector: got %h want 0000", trap_vector); end
    checks++; if (mepc_o !== 16'h0000) begin errors++; $display("FAIL rst_mepc: got %h want 0000", mepc_o); end
    read_csr(12'h344, d);
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL rst_mip: got %h want 0000", d); end
    read_csr(12'hC00, d);
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL rst_cycle: got %h want 0000", d); end
    ext_irq = 1'b0; trap_cause = 16'h0000;
    rst_n = 1'b1;
    repeat (5) @(posedge clk); #1;
    read_csr(12'hC00, d);
    checks++; if (d !== 16'h0005) begin errors++; $display("FAIL cycle_after5: got %h want 0005", d); end
    read_csr(12'hC80, d);
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL cycleh_after5: got %h want 0000", d); end
    csr_op(2'b01, 12'hC00, 16'h0000, old, ill);
    checks++; if (ill !== 1'b1) begin errors++; $display("FAIL cycle_wr_illegal: got %b want 1", ill); end
    checks++; if (old !== 16'h0005) begin errors++; $display("FAIL cycle_wr_old: got %h want 0005", old); end
    read_csr(12'hC00, d);
    checks++; if (d !== 16'h0006) begin errors++; $display("FAIL cycle_after_wr: got %h want 0006", d); end
    csr_op(2'b01, 12'h123, 16'hBEEF, old, ill);
    checks++; if (ill !== 1'b1 || old !== 16'h0000) begin errors++; $display("FAIL unknown_addr: got ill=%b rd=%h want ill=1 rd=0000", ill, old); end
  endtask

  task automatic test_mstatus;
    logic [15:0] d, old;
    logic ill;
    csr_op(2'b01, 12'h300, 16'h0008, old, ill);
    read_csr(12'h300, d);
    checks++; if (d !== 16'h0008) begin errors++; $display("FAIL mstatus_wr: got %h want 0008", d); end
    csr_op(2'b10, 12'h300, 16'h0080, old, ill);
    checks++; if (old !== 16'h0008 || ill !== 1'b0) begin errors++; $display("FAIL mstatus_set_old: got %h ill=%b want 0008 ill=0", old, ill); end
    read_csr(12'h300, d);
    checks++; if (d !== 16'h0088) begin errors++; $display("FAIL mstatus_set: got %h want 0088", d); end
    csr_op(2'b11, 12'h300, 16'h0008, old, ill);
    read_csr(12'h300, d);
    checks++; if (d !== 16'h0080) begin errors++; $display("FAIL mstatus_clr: got %h want 0080", d); end
    csr_op(2'b01, 12'h300, 16'hFFFF, old, ill);
    read_csr(12'h300, d);
    checks++; if (d !== 16'h0088) begin errors++; $display("FAIL mstatus_mask: got %h want 0088", d); end
    csr_op(2'b01, 12'h304, 16'hFFFF, old, ill);
    read_csr(12'h304, d);
    checks++; if (d !== 16'h0888) begin errors++; $display("FAIL mie_mask: got %h want 0888", d); end
    csr_op(2'b01, 12'h341, 16'h1235, old, ill);
    checks++; if (mepc_o !== 16'h1234) begin errors++; $display("FAIL mepc_wr: got %h want 1234", mepc_o); end
    csr_op(2'b01, 12'h340, 16'h5555, old, ill);
    csr_op(2'b10, 12'h340, 16'h0AAA, old, ill);
    read_csr(12'h340, d);
    checks++; if (d !== 16'h5FFF) begin errors++; $display("FAIL mscratch_set: got %h want 5FFF", d); end
  endtask

  task automatic test_reset_abort;
    logic [15:0] d;
    @(negedge clk);
    ex_op = 2'b01; ex_addr = 12'h340; ex_wdata = 16'hAAAA; #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    ex_op = 2'b00;
    read_csr(12'h340, d);
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL abort_mscratch: got %h want 0000", d); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    read_csr(12'hC00, d);
    checks++; if (d !== 16'h0001) begin errors++; $display("FAIL cycle_first_edge: got %h want 0001", d); end
  endtask

  task automatic test_irq_trap;
    logic [15:0] d, old;
    logic ill;
    csr_op(2'b01, 12'h300, 16'h0008, old, ill);
    csr_op(2'b01, 12'h304, 16'h0800, old, ill);
    @(negedge clk); ext_irq = 1'b1;
    repeat (2) @(posedge clk); #1;
    checks++; if (int_req !== 1'b1 || int_cause !== 16'h800B) begin errors++; $display("FAIL irq_ext: got req=%b cause=%h want 1 800B", int_req, int_cause); end
    read_csr(12'h344, d);
    checks++; if (d !== 16'h0800) begin errors++; $display("FAIL mip_ext: got %h want 0800", d); end
    tmr_irq = 1'b1; sw_irq = 1'b1;
    csr_op(2'b01, 12'h304, 16'h0088, old, ill);
    checks++; if (int_cause !== 16'h8003) begin errors++; $display("FAIL irq_sw_prio: got %h want 8003", int_cause); end
    csr_op(2'b01, 12'h304, 16'h0080, old, ill);
    checks++; if (int_cause !== 16'h8007) begin errors++; $display("FAIL irq_tmr: got %h want 8007", int_cause); end
    csr_op(2'b10, 12'h344, 16'h0800, old, ill);
    checks++; if (ill !== 1'b1) begin errors++; $display("FAIL mip_ro: got ill=%b want 1", ill); end
    csr_op(2'b11, 12'h300, 16'h0008, old, ill);
    checks++; if (int_req !== 1'b0 || int_cause !== 16'h0000) begin errors++; $display("FAIL irq_masked: got req=%b cause=%h want 0 0000", int_req, int_cause); end
    ext_irq = 1'b0; tmr_irq = 1'b0; sw_irq = 1'b0;
    csr_op(2'b01, 12'h300, 16'h0008, old, ill);
    @(negedge clk);
    trap_valid = 1'b1; trap_pc = 16'h0123; trap_cause = 16'h800B;
    @(posedge clk); #1;
    trap_valid = 1'b0;
    checks++; if (mepc_o !== 16'h0122) begin errors++; $display("FAIL trap_mepc: got %h want 0122", mepc_o); end
    read_csr(12'h300, d);
    checks++; if (d !== 16'h0080) begin errors++; $display("FAIL trap_mstatus: got %h want 0080", d); end
    read_csr(12'h342, d);
    checks++; if (d !== 16'h800B) begin errors++; $display("FAIL trap_mcause: got %h want 800B", d); end
    @(negedge clk); mret = 1'b1;
    @(posedge clk); #1; mret = 1'b0;
    read_csr(12'h300, d);
    checks++; if (d !== 16'h0088) begin errors++; $display("FAIL mret_mstatus: got %h want 0088", d); end
  endtask

  task automatic test_trap_vector;
    logic [15:0] old;
    logic ill;
    csr_op(2'b01, 12'h305, 16'h0101, old, ill);
    trap_cause = 16'h800B; #1;
    checks++; if (trap_vector !== 16'h012C) begin errors++; $display("FAIL tvec_vectored: got %h want 012C", trap_vector); end
    trap_cause = 16'h000B; #1;
    checks++; if (trap_vector !== 16'h0100) begin errors++; $display("FAIL tvec_exception: got %h want 0100", trap_vector); end
    csr_op(2'b01, 12'h305, 16'h0100, old, ill);
    trap_cause = 16'h800B; #1;
    checks++; if (trap_vector !== 16'h0100) begin errors++; $display("FAIL tvec_direct: got %h want 0100", trap_vector); end
    csr_op(2'b01, 12'h305, 16'h0FFD, old, ill);
    trap_cause = 16'h8007; #1;
    checks++; if (trap_vector !== 16'h1018) begin errors++; $display("FAIL tvec_vec_tmr: got %h want 1018", trap_vector); end
    trap_cause = 16'h0000;
  endtask

  task automatic test_priority;
    logic [15:0] d, old;
    logic ill;
    csr_op(2'b01, 12'h340, 16'h5555, old, ill);
    @(negedge clk);
    trap_valid = 1'b1; mret = 1'b1; retire = 1'b1;
    trap_pc = 16'h0200; trap_cause = 16'h0002;
    ex_op = 2'b01; ex_addr = 12'h340; ex_wdata = 16'h1234;
    @(posedge clk); #1;
    trap_valid = 1'b0; mret = 1'b0; retire = 1'b0; ex_op = 2'b00;
    read_csr(12'h340, d);
    checks++; if (d !== 16'h5555) begin errors++; $display("FAIL prio_mscratch: got %h want 5555", d); end
    read_csr(12'hC02, d);
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL prio_instret: got %h want 0000", d); end
    checks++; if (mepc_o !== 16'h0200) begin errors++; $display("FAIL prio_mepc: got %h want 0200", mepc_o); end
    read_csr(12'h300, d);
    checks++; if (d !== 16'h0080) begin errors++; $display("FAIL prio_mstatus: got %h want 0080", d); end
    @(negedge clk);
    mret = 1'b1; ex_op = 2'b01; ex_addr = 12'h300; ex_wdata = 16'h0000;
    @(posedge clk); #1;
    mret = 1'b0; ex_op = 2'b00;
    read_csr(12'h300, d);
    checks++; if (d !== 16'h0088) begin errors++; $display("FAIL mret_beats_wr: got %h want 0088", d); end
    @(negedge clk); retire = 1'b1;
    repeat (3) @(posedge clk); #1;
    retire = 1'b0;
    read_csr(12'hC02, d);
    checks++; if (d !== 16'h0003) begin errors++; $display("FAIL instret_count: got %h want 0003", d); end
    read_csr(12'hC82, d);
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL instreth: got %h want 0000", d); end
  endtask

  task automatic test_counter_wrap;
    logic [15:0] d;
    logic [11:0] s;
    @(negedge clk); rst_n = 1'b0; s_rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; s_rst_n = 1'b1;
    repeat (4095) @(posedge clk); #1;
    s_read(12'hC00, s);
    checks++; if (s !== 12'hFFF) begin errors++; $display("FAIL s_cycle_4095: got %h want FFF", s); end
    s_read(12'hC80, s);
    checks++; if (s !== 12'h000) begin errors++; $display("FAIL s_cycleh_4095: got %h want 000", s); end
    @(posedge clk); #1;
    s_read(12'hC00, s);
    checks++; if (s !== 12'h000) begin errors++; $display("FAIL s_cycle_4096: got %h want 000", s); end
    s_read(12'hC80, s);
    checks++; if (s !== 12'h001) begin errors++; $display("FAIL s_cycleh_4096: got %h want 001", s); end
    repeat (8191 - 4096) @(posedge clk); #1;
    s_read(12'hC00, s);
    checks++; if (s !== 12'hFFF) begin errors++; $display("FAIL s_cycle_ones: got %h want FFF", s); end
    s_read(12'hC80, s);
    checks++; if (s !== 12'h001) begin errors++; $display("FAIL s_cycleh_ones: got %h want 001", s); end
    @(posedge clk); #1;
    s_read(12'hC00, s);
    checks++; if (s !== 12'h000) begin errors++; $display("FAIL s_cycle_wrap: got %h want 000", s); end
    s_read(12'hC80, s);
    checks++; if (s !== 12'h000) begin errors++; $display("FAIL s_cycleh_wrap: got %h want 000", s); end
    repeat (65535 - 8192) @(posedge clk); #1;
    read_csr(12'hC00, d);
    checks++; if (d !== 16'hFFFF) begin errors++; $display("FAIL cycle_ffff: got %h want FFFF", d); end
    read_csr(12'hC80, d);
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL cycleh_ffff: got %h want 0000", d); end
    @(posedge clk); #1;
    read_csr(12'hC00, d);
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL cycle_carry: got %h want 0000", d); end
    read_csr(12'hC80, d);
    checks++; if (d !== 16'h0001) begin errors++; $display("FAIL cycleh_carry: got %h want 0001", d); end
  endtask

  initial begin
    test_reset();
    test_mstatus();
    test_reset_abort();
    test_irq_trap();
    test_trap_vector();
    test_priority();
    test_counter_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
